// File: rtl/generator_scheduler.sv
// generator_scheduler
//
// Shares a single delay/pulse generator between N_REQ requesters. Pending
// requests are arbitrated round-robin while the scheduler is idle. The
// scheduler loads the winner's delay into the generator and fires a start
// strobe. It then waits for the generator's completion strobe or for a
// timeout. The outcome is reported to the winner, and an optional guard
// gap is enforced before the next arbitration.
//
// Ports
//   clk        : rising-edge clock
//   reset      : synchronous, active-low reset
//   req        : level request per requester
//   req_delay  : packed delay words, requester i in [i*DELAY_W +: DELAY_W]
//   grant      : one-hot grant, held for the whole service of the winner
//   done       : one-cycle pulse to the winner on normal completion
//   err        : one-cycle pulse when the generator timed out
//   gen_start  : one-cycle start strobe to the generator
//   gen_delay  : delay presented to the generator, held until next grant
//   gen_done   : completion strobe from the generator
//   busy       : high while a service is running or in its guard gap
//
// All outputs come straight from flops.

module generator_scheduler #(
  parameter int N_REQ   = 4,
  parameter int DELAY_W = 8,
  parameter int TIMEOUT = 255,
  parameter int GUARD   = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [N_REQ-1:0]           req,
  input  logic [N_REQ*DELAY_W-1:0]   req_delay,
  output logic [N_REQ-1:0]           grant,
  output logic [N_REQ-1:0]           done,
  output logic                       err,
  output logic                       gen_start,
  output logic [DELAY_W-1:0]         gen_delay,
  input  logic                       gen_done,
  output logic                       busy
);

  localparam int PTR_W   = $clog2(N_REQ);
  localparam int CNT_MAX = (TIMEOUT > GUARD) ? TIMEOUT : GUARD;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [PTR_W-1:0] PTR_RESET    = PTR_W'(N_REQ - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] GUARD_LAST   = CNT_W'((GUARD > 0) ? (GUARD - 1) : 0);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    COOL = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [PTR_W-1:0]     ptr_q, ptr_d;
  logic [PTR_W-1:0]     svc_q, svc_d;
  logic [N_REQ-1:0]     grant_q, grant_d;
  logic [N_REQ-1:0]     done_q, done_d;
  logic                 err_q, err_d;
  logic                 gen_start_q, gen_start_d;
  logic [DELAY_W-1:0]   gen_delay_q, gen_delay_d;
  logic                 busy_q, busy_d;

  logic                 win_found;
  logic [PTR_W-1:0]     win_idx;
  logic [N_REQ-1:0]     win_onehot;
  logic                 run_complete;
  logic                 run_timeout;

  // Round-robin search: the first set request bit strictly after the pointer,
  // wrapping around, so the last winner has the lowest priority next time.
  always_comb begin
    win_found  = 1'b0;
    win_idx    = '0;
    win_onehot = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      int cand;
      cand = (int'(ptr_q) + i) % N_REQ;
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = PTR_W'(cand);
      end
    end
    win_onehot[win_idx] = win_found;
  end

  // The first RUN cycle (counter 0) is the start-strobe cycle, so a
  // gen_done seen there cannot belong to this service and is ignored.
  // Completion is checked ahead of the timeout, so a strobe arriving in the
  // timeout cycle still counts as a normal finish.
  always_comb begin
    run_complete = gen_done && (cnt_q != '0);
    run_timeout  = (cnt_q == TIMEOUT_LAST) && !run_complete;
  end

  // Next-state and output logic. Pulsed outputs default low every cycle;
  // grant and gen_delay hold their value unless explicitly changed.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ptr_d       = ptr_q;
    svc_d       = svc_q;
    grant_d     = grant_q;
    done_d      = '0;
    err_d       = 1'b0;
    gen_start_d = 1'b0;
    gen_delay_d = gen_delay_q;

    case (state_q)
      IDLE: begin
        if (win_found) begin
          state_d     = RUN;
          cnt_d       = '0;
          svc_d       = win_idx;
          grant_d     = win_onehot;
          gen_delay_d = req_delay[int'(win_idx)*DELAY_W +: DELAY_W];
          gen_start_d = 1'b1;
        end
      end

      RUN: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (run_complete || run_timeout) begin
          done_d  = run_complete ? grant_q : '0;
          err_d   = run_timeout;
          grant_d = '0;
          ptr_d   = svc_q;
          cnt_d   = '0;
          state_d = (GUARD == 0) ? IDLE : COOL;
        end
      end

      COOL: begin
        if (cnt_q == GUARD_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        grant_d = '0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers. Reset takes priority over everything,
  // including an in-flight service; the generator is not told about it.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      ptr_q       <= PTR_RESET;
      svc_q       <= '0;
      grant_q     <= '0;
      done_q      <= '0;
      err_q       <= 1'b0;
      gen_start_q <= 1'b0;
      gen_delay_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ptr_q       <= ptr_d;
      svc_q       <= svc_d;
      grant_q     <= grant_d;
      done_q      <= done_d;
      err_q       <= err_d;
      gen_start_q <= gen_start_d;
      gen_delay_q <= gen_delay_d;
      busy_q      <= busy_d;
    end
  end

  assign grant     = grant_q;
  assign done      = done_q;
  assign err       = err_q;
  assign gen_start = gen_start_q;
  assign gen_delay = gen_delay_q;
  assign busy      = busy_q;

endmodule
